uart_tx_8n1: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_tick.sv | 36 +++
 rtl/uart_tx_8n1.sv | 121 ++++++++++++
 tb/tb_uart_tx_8n1.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants, state encoding and parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int   UART_BAUD_DIV_DEFAULT = 104;
    localparam int   UART_DATA_BITS        = 8;
    localparam logic UART_STOP_LEVEL       = 1'b1;
    localparam logic UART_START_LEVEL      = 1'b0;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t c_ST_IDLE   = 3'd0;
    localparam uart_state_t c_ST_START  = 3'd1;
    localparam uart_state_t c_ST_DATA   = 3'd2;
    localparam uart_state_t c_ST_PARITY = 3'd3;
    localparam uart_state_t c_ST_STOP   = 3'd4;

    function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module      : uart_baud_tick
// Description : Bit-period counter; one-cycle tick on the last cycle of a bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int BAUD_DIV = 104,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst || i_restart) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_8n1.sv
// ============================================================================
// Module      : uart_tx_8n1
// Description : Valid/ready byte UART transmitter, 8N1 (8E1 when the
//               UART_TX_PARITY_EN macro is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_8n1
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = UART_BAUD_DIV_DEFAULT,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       PMOD4,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       RS232_Tx
);

`ifdef UART_TX_PARITY_EN
    localparam int c_BIT_W = 4;
`else
    localparam int c_BIT_W = 3;
`endif
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(UART_DATA_BITS - 1);

    uart_state_t        r_state;
    uart_state_t        w_state_next;
    logic [7:0]         r_shift;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic               w_tick;
    logic               w_accept;
    logic               w_restart;
`ifdef UART_TX_PARITY_EN
    logic               r_parity;
`endif

    assign w_accept  = tx_valid & tx_ready;
    // Hold the bit timer at zero while idle so START gets a full bit period.
    assign w_restart = (r_state == c_ST_IDLE);

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV),
        .CNT_W    (CNT_W)
    ) u_baud_tick (
        .clk       (clk),
        .rst       (PMOD4),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (PMOD4) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_accept) w_state_next = c_ST_START;
            c_ST_START:  if (w_tick)   w_state_next = c_ST_DATA;
            c_ST_DATA: begin
                if (w_tick && (r_bit_cnt == c_LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = c_ST_PARITY;
`else
                    w_state_next = c_ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            c_ST_PARITY: if (w_tick)   w_state_next = c_ST_STOP;
`endif
            c_ST_STOP:   if (w_tick)   w_state_next = c_ST_IDLE;
            default:                   w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (PMOD4) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_shift   <= tx_data;
            r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= uart_even_parity(tx_data);
`endif
        end else if ((r_state == c_ST_DATA) && w_tick) begin
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    always_comb begin
        tx_ready = (r_state == c_ST_IDLE);
        tx_busy  = ~tx_ready;
        RS232_Tx = UART_STOP_LEVEL;
        case (r_state)
            c_ST_START:  RS232_Tx = UART_START_LEVEL;
            c_ST_DATA:   RS232_Tx = r_shift[0];
`ifdef UART_TX_PARITY_EN
            c_ST_PARITY: RS232_Tx = r_parity;
`endif
            default:     RS232_Tx = UART_STOP_LEVEL;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_8n1.sv
// ============================================================================
// Module      : tb_uart_tx_8n1
// Description : Self-checking bench for uart_tx_8n1 against a frame model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_8n1;

    localparam int BD = 104;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BD;

    logic       clk = 1'b0;
    logic       PMOD4 = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_busy;
    logic       RS232_Tx;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_start = 0;

    uart_tx_8n1 #(
        .BAUD_DIV (BD),
        .CNT_W    (8)
    ) dut (
        .clk      (clk),
        .PMOD4    (PMOD4),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .RS232_Tx (RS232_Tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Sends d and checks the whole frame cycle by cycle. With chain set, the
    // next byte is presented (valid held) as soon as d is accepted.
    task automatic run_frame(input logic [7:0] d, input bit chain,
                             input logic [7:0] nd, input int noise_k);
        bit         exp_bits[NBITS];
        int         match[NBITS];
        int         ready_low = 0;
        int         busy_ok = 0;
        logic [7:0] dec = 8'h00;
        logic       par_seen = 1'b0;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
        exp_bits[9] = ^d;
`endif
        exp_bits[NBITS-1] = 1'b1;
        for (int j = 0; j < NBITS; j++) match[j] = 0;

        tx_data  = d;
        tx_valid = 1'b1;
        step();
        last_start = cyc;
        if (chain) tx_data = nd;
        else       tx_valid = 1'b0;

        for (int k = 0; k < FRAME; k++) begin
            if (noise_k >= 0 && k == noise_k) begin
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
            end
            if (noise_k >= 0 && k == noise_k + 1) tx_valid = 1'b0;
            if (RS232_Tx === exp_bits[k / BD]) match[k / BD]++;
            if (tx_ready === 1'b0) ready_low++;
            if (tx_busy === ~tx_ready) busy_ok++;
            if (k % BD == BD / 2) begin
                if (k / BD >= 1 && k / BD <= 8) dec[k / BD - 1] = RS232_Tx;
                if (k / BD == 9 && NBITS == 11) par_seen = RS232_Tx;
            end
            step();
        end

        for (int j = 0; j < NBITS; j++) check($sformatf("bit%0d_cycles_%02h", j, d), match[j], BD);
        check($sformatf("ready_low_%02h", d), ready_low, FRAME);
        check($sformatf("busy_inv_%02h", d), busy_ok, FRAME);
        check($sformatf("decoded_%02h", d), dec, d);
`ifdef UART_TX_PARITY_EN
        check($sformatf("parity_%02h", d), par_seen, ^d);
`else
        check($sformatf("no_parity_sample_%02h", d), par_seen, 1'b0);
`endif
        check($sformatf("ready_after_%02h", d), tx_ready, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s1;
        int s2;
        int high_cnt;
        logic [7:0] d;
        logic [7:0] nd;
        bit ch;

        // Reset held with valid asserted: nothing may start.
        PMOD4    = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_line_%0d", i), RS232_Tx, 1'b1);
            check($sformatf("rst_ready_%0d", i), tx_ready, 1'b1);
            check($sformatf("rst_busy_%0d", i), tx_busy, 1'b0);
        end
        tx_valid = 1'b0;
        PMOD4    = 1'b0;
        step();
        check("idle_line", RS232_Tx, 1'b1);

        run_frame(8'h55, 1'b0, 8'h00, -1);
        step();
        run_frame(8'h01, 1'b0, 8'h00, -1);
        step();

        // Back-to-back with valid held across the boundary.
        run_frame(8'hA5, 1'b1, 8'h3C, -1);
        s1 = last_start;
        run_frame(8'h3C, 1'b0, 8'h00, -1);
        s2 = last_start;
        check("b2b_gap", s2 - s1, FRAME + 1);
        step();

        // Byte offered mid-DATA must be ignored.
        run_frame(8'h00, 1'b0, 8'h00, 4 * BD);
        step();

`ifdef UART_TX_PARITY_EN
        run_frame(8'h07, 1'b0, 8'h00, -1);
        step();
        run_frame(8'h03, 1'b0, 8'h00, -1);
        step();
`endif

        // Reset in the middle of a frame.
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        check("midrst_started", RS232_Tx, 1'b0);
        repeat (500) step();
        PMOD4 = 1'b1;
        step();
        check("midrst_line", RS232_Tx, 1'b1);
        check("midrst_ready", tx_ready, 1'b1);
        check("midrst_busy", tx_busy, 1'b0);
        step();
        PMOD4 = 1'b0;
        step();
        check("postrst_ready", tx_ready, 1'b1);
        high_cnt = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (RS232_Tx === 1'b1 && tx_ready === 1'b1) high_cnt++;
            step();
        end
        check("postrst_idle", high_cnt, FRAME);

        // Randomized bytes, randomly chained or separated by short gaps.
        d = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            ch = (i < 7) && ($urandom_range(0, 1) == 1);
            nd = 8'($urandom);
            run_frame(d, ch, nd, -1);
            if (!ch) begin
                repeat ($urandom_range(0, 3)) step();
                d = 8'($urandom);
            end else begin
                d = nd;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
